// File: rtl/eth_rx_frame.sv
// ============================================================================
// Module   : eth_rx_frame
// Function : RGMII receive framer with preamble/SFD detection, CRC-32 check,
//            FCS strip, length check and good/bad frame counters.
// Option   : ETH_RX_DEST_FILTER_EN enables destination-address filtering.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module eth_rx_frame #(
  parameter int          MIN_LEN  = 60,
  parameter int          MAX_LEN  = 1514,
  parameter logic [47:0] MAC_ADDR = 48'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic [1:0]  rx_ctl,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_good,
  output logic [10:0] out_len,
  output logic [15:0] good_count,
  output logic [15:0] bad_count
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_DATA     = 3'd2,
    S_FLUSH    = 3'd3,
    S_DROP     = 3'd4
  } state_t;

  localparam logic [31:0] c_crc_poly    = 32'hEDB88320;
  localparam logic [31:0] c_crc_init    = 32'hFFFFFFFF;
  localparam logic [31:0] c_crc_residue = 32'hDEBB20E3;
  localparam logic [10:0] c_min_len     = 11'(MIN_LEN);
  localparam logic [10:0] c_max_len     = 11'(MAX_LEN);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_crc;
  logic        r_err;
  logic [11:0] r_n;
  logic [7:0]  r_dly [6];
  logic        r_flush_2nd;
  logic        r_rst_d;

  logic        w_dv, w_er, w_pass, w_good;
  logic        w_start, w_accept, w_emit, w_last, w_good_inc, w_bad_inc;
  logic [11:0] w_len_raw;
  logic [10:0] w_len;

  assign w_dv      = rx_ctl[0];
  assign w_er      = rx_ctl[0] ^ rx_ctl[1];
  assign w_len_raw = r_n - 12'd4;
  assign w_len     = w_len_raw[11] ? 11'h7FF : w_len_raw[10:0];
  assign w_good    = (r_crc == c_crc_residue) && !r_err &&
                     (w_len >= c_min_len) && (w_len <= c_max_len);

  function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++)
      c = (c >> 1) ^ ((c[0] ^ d[i]) ? c_crc_poly : 32'h0);
    return c;
  endfunction

`ifdef ETH_RX_DEST_FILTER_EN
  logic       r_ucast, r_bcast;
  logic [7:0] w_mac_byte;

  always_comb begin
    w_mac_byte = 8'h00;
    case (r_n[2:0])
      3'd0:    w_mac_byte = MAC_ADDR[47:40];
      3'd1:    w_mac_byte = MAC_ADDR[39:32];
      3'd2:    w_mac_byte = MAC_ADDR[31:24];
      3'd3:    w_mac_byte = MAC_ADDR[23:16];
      3'd4:    w_mac_byte = MAC_ADDR[15:8];
      3'd5:    w_mac_byte = MAC_ADDR[7:0];
      default: w_mac_byte = 8'h00;
    endcase
  end

  // Both match flags settle once byte 5 is in, before the first byte is emitted.
  always_ff @(posedge clk) begin
    if (reset || w_start) begin
      r_ucast <= 1'b1;
      r_bcast <= 1'b1;
    end else if (w_accept && (r_n < 12'd6)) begin
      r_ucast <= r_ucast & (rx_data == w_mac_byte);
      r_bcast <= r_bcast & (rx_data == 8'hFF);
    end
  end

  assign w_pass = r_ucast | r_bcast;
`else
  logic w_unused_mac;
  assign w_unused_mac = ^MAC_ADDR;
  assign w_pass       = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_accept    = 1'b0;
    w_emit      = 1'b0;
    w_last      = 1'b0;
    w_good_inc  = 1'b0;
    w_bad_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_dv) begin
          if (r_rst_d)               w_state_nxt = S_DROP;
          else if (rx_data == 8'h55) w_state_nxt = S_PREAMBLE;
          else if (rx_data == 8'hD5) begin
            w_state_nxt = S_DATA;
            w_start     = 1'b1;
          end else                   w_state_nxt = S_DROP;
        end
      end
      S_PREAMBLE: begin
        if (!w_dv)                 w_state_nxt = S_IDLE;
        else if (rx_data == 8'hD5) begin
          w_state_nxt = S_DATA;
          w_start     = 1'b1;
        end else if (rx_data != 8'h55) w_state_nxt = S_DROP;
      end
      S_DATA: begin
        if (w_dv) begin
          w_accept = 1'b1;
          w_emit   = (r_n >= 12'd6);
        end else if (r_n >= 12'd6) begin
          w_state_nxt = S_FLUSH;
          w_emit      = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
          w_bad_inc   = 1'b1;
        end
      end
      S_FLUSH: begin
        if (!r_flush_2nd) begin
          w_emit = 1'b1;
          w_last = 1'b1;
        end else begin
          // out_good is on the output this cycle alongside out_eof
          w_state_nxt = w_dv ? S_DROP : S_IDLE;
          w_good_inc  = w_pass & out_good;
          w_bad_inc   = w_pass & ~out_good;
        end
      end
      S_DROP: begin
        if (!w_dv) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_crc       <= c_crc_init;
      r_err       <= 1'b0;
      r_n         <= 12'd0;
      r_flush_2nd <= 1'b0;
      r_rst_d     <= 1'b1;
      for (int i = 0; i < 6; i++) r_dly[i] <= 8'h00;
      out_data    <= 8'h00;
      out_valid   <= 1'b0;
      out_sof     <= 1'b0;
      out_eof     <= 1'b0;
      out_good    <= 1'b0;
      out_len     <= 11'd0;
      good_count  <= 16'd0;
      bad_count   <= 16'd0;
    end else begin
      r_rst_d     <= 1'b0;
      r_flush_2nd <= (r_state == S_FLUSH) && !r_flush_2nd;
      if (w_start) begin
        r_crc <= c_crc_init;
        r_err <= 1'b0;
        r_n   <= 12'd0;
      end else if (w_accept) begin
        r_crc <= crc_next(r_crc, rx_data);
        if (w_er) r_err <= 1'b1;
        if (r_n != 12'hFFF) r_n <= r_n + 12'd1;
      end
      // Oldest entry always leaves on emit; flush pushes filler behind it.
      if (w_accept || w_emit) begin
        r_dly[0] <= w_accept ? rx_data : 8'h00;
        for (int i = 1; i < 6; i++) r_dly[i] <= r_dly[i-1];
      end
      out_valid <= w_emit & w_pass;
      out_data  <= (w_emit & w_pass) ? r_dly[5] : 8'h00;
      out_sof   <= w_emit & w_pass & (r_state == S_DATA) & (r_n == 12'd6);
      out_eof   <= w_last & w_pass;
      out_good  <= w_last & w_pass & w_good;
      out_len   <= (w_last & w_pass) ? w_len : 11'd0;
      if (w_good_inc) good_count <= good_count + 16'd1;
      if (w_bad_inc)  bad_count  <= bad_count + 16'd1;
    end
  end

endmodule

`default_nettype wire
